// File: rtl/l2_mem_pkg.sv
// Shared L2/memory-side types for the EWB drain: FSM state encoding, beat geometry, line/beat types.
package l2_mem_pkg;

    localparam int L2_LINE_W  = 256;
    localparam int L2_BEAT_W  = 64;
    localparam int BEATS      = L2_LINE_W / L2_BEAT_W;
    localparam int BEAT_IDX_W = $clog2(BEATS);

    typedef logic [L2_LINE_W-1:0] line_t;
    typedef logic [L2_BEAT_W-1:0] beat_t;

    // Encodings kept as plain constants so older code can still compare against raw values.
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WB      = 3'd1;
    localparam logic [2:0] S_WB_DONE = 3'd2;
    localparam logic [2:0] S_RD      = 3'd3;
    localparam logic [2:0] S_RD_DONE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_WB      = S_WB,
        ST_WB_DONE = S_WB_DONE,
        ST_RD      = S_RD,
        ST_RD_DONE = S_RD_DONE
    } drain_state_t;

endpackage

// File: rtl/ewb_drain_line_beat_buf.sv
// Line buffer shared by write-back and fill: parallel load, beat-indexed fill write,
// beat-indexed read mux, and the wrapping beat counter.
module line_beat_buf #(
    parameter int  LINE_W = 256,
    parameter int  BEAT_W = 64,
    localparam int NBEATS = LINE_W / BEAT_W,
    localparam int IDX_W  = $clog2(NBEATS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [LINE_W-1:0] load_data_i,
    input  logic              fill_we_i,
    input  logic [BEAT_W-1:0] fill_data_i,
    input  logic              beat_clr_i,
    input  logic              beat_inc_i,
    output logic [IDX_W-1:0]  beat_o,
    output logic [BEAT_W-1:0] beat_data_o,
    output logic [LINE_W-1:0] line_o
);

    logic [LINE_W-1:0] line_q, line_d;
    logic [IDX_W-1:0]  beat_q, beat_d;

    // Next line contents: whole-line snapshot or a single filled beat.
    always_comb begin
        line_d = line_q;
        if (load_i) begin
            line_d = load_data_i;
        end else if (fill_we_i) begin
            line_d[BEAT_W*beat_q +: BEAT_W] = fill_data_i;
        end else begin
            line_d = line_q;
        end
    end

    // Beat counter wraps naturally after the last beat.
    always_comb begin
        if (beat_clr_i) begin
            beat_d = {IDX_W{1'b0}};
        end else if (beat_inc_i) begin
            beat_d = beat_q + IDX_W'(1);
        end else begin
            beat_d = beat_q;
        end
    end

    // Buffer and counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= {LINE_W{1'b0}};
            beat_q <= {IDX_W{1'b0}};
        end else begin
            line_q <= line_d;
            beat_q <= beat_d;
        end
    end

    assign beat_o      = beat_q;
    assign beat_data_o = line_q[BEAT_W*beat_q +: BEAT_W];
    assign line_o      = line_q;

endmodule

// File: rtl/ewb_drain.sv
// EWB drain: write-back of EWB head lines and L2 line fills over one 4-beat burst port.
// Define EWB_READ_PRIORITY_EN to let fills always win over write-backs; otherwise round-robin.
module ewb_drain
    import l2_mem_pkg::*;
#(
    parameter int LINE_W = L2_LINE_W,
    parameter int BEAT_W = L2_BEAT_W,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ewb_empty_i,
    input  logic [LINE_W-1:0] ewb_data_i,
    input  logic [ADDR_W-1:0] ewb_addr_i,
    output logic              ewb_yumi_o,
    output logic              ewb_lock_o,
    input  logic              l2_read_i,
    input  logic [ADDR_W-1:0] l2_addr_i,
    output logic [LINE_W-1:0] l2_rdata_o,
    output logic              l2_resp_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [BEAT_W-1:0] mem_wdata_o,
    input  logic [BEAT_W-1:0] mem_rdata_i,
    input  logic              mem_resp_i
);

    localparam int NBEATS = LINE_W / BEAT_W;
    localparam int IDX_W  = $clog2(NBEATS);
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam logic [IDX_W-1:0] BEAT_LAST = IDX_W'(NBEATS - 1);

    drain_state_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              grant_wb_s, grant_rd_s;
    logic              load_s, fill_we_s, beat_clr_s, beat_inc_s;
    logic [IDX_W-1:0]  beat_s;
    logic [BEAT_W-1:0] beat_data_s;
    logic [LINE_W-1:0] line_s;
    logic              unused_s;

    assign unused_s = ^{ewb_addr_i[OFF_W-1:0], l2_addr_i[OFF_W-1:0]};

`ifdef EWB_READ_PRIORITY_EN
    // Fills are latency-critical: any pending read beats a pending write-back.
    always_comb begin
        grant_wb_s = 1'b0;
        grant_rd_s = 1'b0;
        if (l2_read_i) begin
            grant_rd_s = 1'b1;
        end else if (!ewb_empty_i) begin
            grant_wb_s = 1'b1;
        end else begin
            grant_rd_s = 1'b0;
        end
    end
`else
    logic rr_q, rr_d;

    // Round-robin on contention; rr_q=0 favours the write-back, a lone requester always wins.
    always_comb begin
        grant_wb_s = 1'b0;
        grant_rd_s = 1'b0;
        if (l2_read_i && !ewb_empty_i) begin
            grant_rd_s = rr_q;
            grant_wb_s = !rr_q;
        end else if (l2_read_i) begin
            grant_rd_s = 1'b1;
        end else if (!ewb_empty_i) begin
            grant_wb_s = 1'b1;
        end else begin
            grant_rd_s = 1'b0;
        end
    end

    // Fairness bit flips on every burst that is started.
    always_comb begin
        if ((state_q == ST_IDLE) && (grant_wb_s || grant_rd_s)) begin
            rr_d = !rr_q;
        end else begin
            rr_d = rr_q;
        end
    end

    // Fairness bit register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // Burst sequencing; the head entry is only popped after all beats are accepted.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        load_s     = 1'b0;
        fill_we_s  = 1'b0;
        beat_clr_s = 1'b0;
        beat_inc_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                beat_clr_s = 1'b1;
                if (grant_wb_s) begin
                    state_d = ST_WB;
                    load_s  = 1'b1;
                    addr_d  = {ewb_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                end else if (grant_rd_s) begin
                    state_d = ST_RD;
                    addr_d  = {l2_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WB: begin
                if (mem_resp_i) begin
                    beat_inc_s = 1'b1;
                    state_d    = (beat_s == BEAT_LAST) ? ST_WB_DONE : ST_WB;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_RD: begin
                if (mem_resp_i) begin
                    beat_inc_s = 1'b1;
                    fill_we_s  = 1'b1;
                    state_d    = (beat_s == BEAT_LAST) ? ST_RD_DONE : ST_RD;
                end else begin
                    state_d = ST_RD;
                end
            end
            ST_WB_DONE: state_d = ST_IDLE;
            ST_RD_DONE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM state and latched line address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= {ADDR_W{1'b0}};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    line_beat_buf #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load_s),
        .load_data_i (ewb_data_i),
        .fill_we_i   (fill_we_s),
        .fill_data_i (mem_rdata_i),
        .beat_clr_i  (beat_clr_s),
        .beat_inc_i  (beat_inc_s),
        .beat_o      (beat_s),
        .beat_data_o (beat_data_s),
        .line_o      (line_s)
    );

    // Outputs decode only from registered state, so reset clears them immediately.
    always_comb begin
        ewb_yumi_o    = (state_q == ST_WB_DONE);
        ewb_lock_o    = (state_q == ST_WB) || (state_q == ST_WB_DONE);
        l2_resp_o     = (state_q == ST_RD_DONE);
        l2_rdata_o    = (state_q == ST_RD_DONE) ? line_s : {LINE_W{1'b0}};
        mem_write_o   = (state_q == ST_WB);
        mem_read_o    = (state_q == ST_RD);
        mem_address_o = ((state_q == ST_WB) || (state_q == ST_RD)) ? addr_q : {ADDR_W{1'b0}};
        mem_wdata_o   = (state_q == ST_WB) ? beat_data_s : {BEAT_W{1'b0}};
    end

endmodule

// File: tb/tb_ewb_drain.sv
// Randomised bench for ewb_drain: transaction-level reference model, per-cycle compare, directed pins.
module tb_ewb_drain;
    import l2_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ewb_empty_i = 1'b1;
    line_t       ewb_data_i = '0;
    logic [31:0] ewb_addr_i = 32'h0;
    logic        ewb_yumi_o, ewb_lock_o;
    logic        l2_read_i = 1'b0;
    logic [31:0] l2_addr_i = 32'h0;
    line_t       l2_rdata_o;
    logic        l2_resp_o, mem_read_o, mem_write_o;
    logic [31:0] mem_address_o;
    logic [63:0] mem_wdata_o;
    logic [63:0] mem_rdata_i = 64'h0;
    logic        mem_resp_i = 1'b0;

    ewb_drain dut (
        .clk(clk), .rst(rst),
        .ewb_empty_i(ewb_empty_i), .ewb_data_i(ewb_data_i), .ewb_addr_i(ewb_addr_i),
        .ewb_yumi_o(ewb_yumi_o), .ewb_lock_o(ewb_lock_o),
        .l2_read_i(l2_read_i), .l2_addr_i(l2_addr_i), .l2_rdata_o(l2_rdata_o), .l2_resp_o(l2_resp_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_address_o(mem_address_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_resp_i(mem_resp_i)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rd_beat(input logic [31:0] a, input int k);
        return {8{8'(8'h11 * (k + 1))}} ^ {32'h0, a ^ 32'h8000_0040};
    endfunction

    function automatic line_t rand_line();
        line_t l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Reference model: one burst at a time, described as {kind, address, line, beats accepted}.
    bit    m_busy = 1'b0, m_rd = 1'b0, m_done = 1'b0, m_rr = 1'b0, m_pick;
    logic [31:0] m_addr = 32'h0;
    line_t m_line = '0;
    int    m_cnt = 0;

    always_comb begin
`ifdef EWB_READ_PRIORITY_EN
        m_pick = l2_read_i;
`else
        m_pick = l2_read_i && (ewb_empty_i || m_rr);
`endif
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_rd <= 1'b0; m_rr <= 1'b0;
            m_addr <= 32'h0; m_line <= '0; m_cnt <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_busy) begin
            if (mem_resp_i) begin
                if (m_rd) m_line[m_cnt*64 +: 64] <= mem_rdata_i;
                m_cnt <= m_cnt + 1;
                if (m_cnt == 3) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
            end
        end else if (l2_read_i || !ewb_empty_i) begin
            m_busy <= 1'b1;
            m_rd   <= m_pick;
            m_cnt  <= 0;
            m_addr <= (m_pick ? l2_addr_i : ewb_addr_i) & 32'hFFFF_FFE0;
            m_line <= m_pick ? line_t'(0) : ewb_data_i;
            m_rr   <= !m_rr;
        end
    end

    // Per-cycle compare against the model.
    initial forever begin
        @(negedge clk);
        check("mem_write", 256'(mem_write_o), 256'(m_busy && !m_rd));
        check("mem_read", 256'(mem_read_o), 256'(m_busy && m_rd));
        check("mem_address", 256'(mem_address_o), 256'(m_busy ? m_addr : 32'h0));
        check("mem_wdata", 256'(mem_wdata_o), 256'((m_busy && !m_rd) ? m_line[m_cnt*64 +: 64] : 64'h0));
        check("ewb_lock", 256'(ewb_lock_o), 256'((m_busy || m_done) && !m_rd));
        check("ewb_yumi", 256'(ewb_yumi_o), 256'(m_done && !m_rd));
        check("l2_resp", 256'(l2_resp_o), 256'(m_done && m_rd));
        check("l2_rdata", l2_rdata_o, (m_done && m_rd) ? m_line : 256'h0);
    end

    // Event logs for the directed checks.
    logic [63:0] wr_log[$];
    logic [31:0] wa_log[$];
    line_t       rd_log[$];
    bit          grant_log[$];
    int          yumi_cnt = 0, resp_cnt = 0;
    bit          prev_act = 1'b0;

    initial forever begin
        @(negedge clk);
        if (ewb_yumi_o) yumi_cnt++;
        if (l2_resp_o) begin
            resp_cnt++;
            rd_log.push_back(l2_rdata_o);
        end
        if ((mem_read_o || mem_write_o) && !prev_act) grant_log.push_back(mem_read_o);
        prev_act = mem_read_o || mem_write_o;
    end

    // Memory responder: one beat per resp, random or fixed gaps, optional stray pulses when idle.
    int gap_cnt = 0, rbeat = 0, stray_seq = 0, stray_done = 0, fixed_gap = -1;

    initial forever begin
        @(negedge clk);
        #1;
        mem_resp_i  = 1'b0;
        mem_rdata_i = {$urandom, $urandom};
        if (rst) begin
            gap_cnt = 0;
            rbeat   = 0;
        end else if (mem_read_o || mem_write_o) begin
            if (gap_cnt > 0) begin
                gap_cnt--;
            end else begin
                mem_resp_i  = 1'b1;
                mem_rdata_i = rd_beat(mem_address_o, rbeat);
                if (mem_write_o) begin
                    wr_log.push_back(mem_wdata_o);
                    wa_log.push_back(mem_address_o);
                end
                rbeat   = (rbeat + 1) % 4;
                gap_cnt = (fixed_gap >= 0) ? fixed_gap : int'($urandom_range(0, 3));
            end
        end else if (stray_done != stray_seq) begin
            mem_resp_i = 1'b1;
            stray_done++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ewb_empty_i = 1'b1;
        l2_read_i = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_ev(input int ev, input int target, input string nm);
        int cur;
        for (int i = 0; i < 400; i++) begin
            case (ev)
                0: cur = yumi_cnt;
                1: cur = resp_cnt;
                2: cur = wr_log.size();
                default: cur = grant_log.size();
            endcase
            if (cur >= target) return;
            tick();
        end
        n_cmp++;
        n_bad++;
        $display("FAIL timeout %s: count %0d expected %0d", nm, cur, target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    logic [63:0] t1_beats [4] = '{64'hA000_0000_0000_00D0, 64'hA111_0000_0000_00D1,
                                   64'hA222_0000_0000_00D2, 64'hA333_0000_0000_00D3};
    logic [63:0] t4_beats [4] = '{64'h4444_0000_0000_0000, 64'h4444_1111_0000_0000,
                                   64'h4444_2222_0000_0000, 64'h4444_3333_0000_0000};
    int    y0, r0, w0, w1, g0;
    bit    stop_new;
    logic [2:0] g_exp;
    line_t exp_line;

    initial begin
        // Reset state.
        do_reset();
        check("reset mem_write", 256'(mem_write_o), 256'(0));
        check("reset l2_rdata", l2_rdata_o, 256'h0);

        // 1: single write-back.
        y0 = yumi_cnt; w0 = wr_log.size();
        ewb_addr_i = 32'h0000_1234;
        ewb_data_i = {t1_beats[3], t1_beats[2], t1_beats[1], t1_beats[0]};
        ewb_empty_i = 1'b0;
        wait_ev(0, y0 + 1, "t1 yumi");
        ewb_empty_i = 1'b1;
        repeat (3) tick();
        check("t1 yumi count", 256'(yumi_cnt - y0), 256'(1));
        check("t1 beats", 256'(wr_log.size() - w0), 256'(4));
        check("t1 address", 256'(wa_log[w0]), 256'(32'h0000_1220));
        for (int k = 0; k < 4; k++) check("t1 wdata", 256'(wr_log[w0+k]), 256'(t1_beats[k]));

        // 2: single fill.
        y0 = yumi_cnt; r0 = resp_cnt;
        l2_addr_i = 32'h8000_0040;
        l2_read_i = 1'b1;
        wait_ev(1, r0 + 1, "t2 resp");
        l2_read_i = 1'b0;
        repeat (3) tick();
        check("t2 rdata", rd_log[r0], {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}});
        check("t2 resp count", 256'(resp_cnt - r0), 256'(1));
        check("t2 no yumi", 256'(yumi_cnt - y0), 256'(0));

        // 3: contention three times from reset.
        do_reset();
        g0 = grant_log.size();
        ewb_addr_i = 32'h0000_9900; ewb_data_i = rand_line(); l2_addr_i = 32'h0000_7700;
        ewb_empty_i = 1'b0; l2_read_i = 1'b1;
        stop_new = 1'b0;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (grant_log.size() >= g0 + 3) stop_new = 1'b1;
            if (stop_new && ewb_yumi_o) ewb_empty_i = 1'b1;
            if (stop_new && l2_resp_o) l2_read_i = 1'b0;
            if (stop_new && ewb_empty_i && !l2_read_i) break;
        end
        repeat (3) tick();
`ifdef EWB_READ_PRIORITY_EN
        g_exp = 3'b111;
`else
        g_exp = 3'b010;
`endif
        for (int i = 0; i < 3; i++) check("t3 grant is_read", 256'(grant_log[g0+i]), 256'(g_exp[i]));

        // 4: head modified mid-burst.
        y0 = yumi_cnt; w0 = wr_log.size();
        ewb_addr_i = 32'h0000_4000;
        ewb_data_i = {t4_beats[3], t4_beats[2], t4_beats[1], t4_beats[0]};
        ewb_empty_i = 1'b0;
        wait_ev(2, w0 + 2, "t4 beat1");
        ewb_data_i = rand_line();
        check("t4 lock", 256'(ewb_lock_o), 256'(1));
        wait_ev(0, y0 + 1, "t4 yumi");
        ewb_empty_i = 1'b1;
        check("t4 beat2", 256'(wr_log[w0+2]), 256'(t4_beats[2]));
        check("t4 beat3", 256'(wr_log[w0+3]), 256'(t4_beats[3]));

        // 5: reset in the middle of a write-back.
        y0 = yumi_cnt; w0 = wr_log.size();
        ewb_addr_i = 32'h0000_5A5F;
        ewb_data_i = {t1_beats[0], t4_beats[1], t1_beats[2], t4_beats[3]};
        ewb_empty_i = 1'b0;
        wait_ev(2, w0 + 2, "t5 beat2");
        rst = 1'b1;
        #1;
        check("t5 async mem_write", 256'(mem_write_o), 256'(0));
        check("t5 async lock", 256'(ewb_lock_o), 256'(0));
        check("t5 async address", 256'(mem_address_o), 256'(0));
        repeat (2) tick();
        rst = 1'b0;
        w1 = wr_log.size();
        check("t5 no yumi in reset", 256'(yumi_cnt - y0), 256'(0));
        wait_ev(0, y0 + 1, "t5 yumi");
        ewb_empty_i = 1'b1;
        check("t5 address", 256'(wa_log[w1]), 256'(32'h0000_5A40));
        check("t5 beat0", 256'(wr_log[w1]), 256'(t4_beats[3]));
        check("t5 beat3", 256'(wr_log[w1+3]), 256'(t1_beats[0]));

        // 6: stray response in idle, then a stalled fill.
        repeat (3) tick();
        g0 = grant_log.size();
        stray_seq++;
        repeat (4) tick();
        check("t6 stray no grant", 256'(grant_log.size() - g0), 256'(0));
        fixed_gap = 10;
        r0 = resp_cnt;
        l2_addr_i = 32'h0000_4567;
        l2_read_i = 1'b1;
        wait_ev(1, r0 + 1, "t6 resp");
        l2_read_i = 1'b0;
        fixed_gap = -1;
        for (int k = 0; k < 4; k++) exp_line[k*64 +: 64] = rd_beat(32'h0000_4560, k);
        repeat (2) tick();
        check("t6 rdata", rd_log[r0], exp_line);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (ewb_yumi_o) begin
                ewb_empty_i = ($urandom_range(0, 3) == 0);
                ewb_addr_i = $urandom;
                ewb_data_i = rand_line();
            end else if (ewb_empty_i && ($urandom_range(0, 7) == 0)) begin
                ewb_empty_i = 1'b0;
                ewb_addr_i = $urandom;
                ewb_data_i = rand_line();
            end else if (ewb_lock_o && ($urandom_range(0, 15) == 0)) begin
                ewb_data_i = rand_line();
            end
            if (l2_read_i) begin
                if (l2_resp_o) l2_read_i = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
                l2_read_i = 1'b1;
                l2_addr_i = $urandom;
            end
            if ($urandom_range(0, 40) == 0) stray_seq++;
        end
        for (int c = 0; c < 200; c++) begin
            tick();
            if (l2_resp_o) l2_read_i = 1'b0;
            if (!ewb_lock_o) ewb_empty_i = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
